// File: rtl/robo_pkg.sv
// Shared encodings for the robot-vacuum motion controller.
// States, directions, battery codes and the invalid-code test.
package robo_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MOVE  = 3'd2,
    ST_LOW   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] DIR_F = 2'b00;
  localparam logic [1:0] DIR_A = 2'b01;
  localparam logic [1:0] DIR_E = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  localparam logic [2:0] BAT_HIGH = 3'b111;
  localparam logic [2:0] BAT_MID  = 3'b011;
  localparam logic [2:0] BAT_LOW  = 3'b001;

  // code is {alto, medio, baixo}
  function automatic logic bat_invalid(input logic [2:0] c);
    return !c[0] | (c[2] & !c[1]);
  endfunction

endpackage

// File: rtl/robo_debounce.sv
// 2-FF synchronizer plus stability-counter debouncer.
// Output follows the synced input after DEB_CYC stable cycles.
module robo_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_deb;

endmodule

// File: rtl/robo_motion_ctrl.sv
// Motion sequencer: input conditioning, battery fault filter,
// direction arbitration and the OFF/IDLE/MOVE/LOW/FAULT FSM.
module robo_motion_ctrl
  import robo_pkg::*;
#(
  parameter int DEB_CYC      = 4,
  parameter int MIN_MOVE_CYC = 8,
  parameter int ERR_FILT_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       f,
  input  logic       a,
  input  logic       e,
  input  logic       d,
  input  logic       alto,
  input  logic       medio,
  input  logic       baixo,
  output logic       move,
  output logic [1:0] dir,
  output logic [2:0] state,
  output logic       fault,
  output logic       low_batt,
  output logic       rgb_ok
);

  localparam int MC = $clog2(MIN_MOVE_CYC + 1);
  localparam int EC = $clog2(ERR_FILT_CYC + 1);

  logic w_ld, w_f, w_a, w_e, w_d;

  robo_debounce #(.DEB_CYC(DEB_CYC)) u_ld (
    .clk(clk), .rst(rst), .din(ld), .dout(w_ld));
  robo_debounce #(.DEB_CYC(DEB_CYC)) u_f (
    .clk(clk), .rst(rst), .din(f), .dout(w_f));
  robo_debounce #(.DEB_CYC(DEB_CYC)) u_a (
    .clk(clk), .rst(rst), .din(a), .dout(w_a));
  robo_debounce #(.DEB_CYC(DEB_CYC)) u_e (
    .clk(clk), .rst(rst), .din(e), .dout(w_e));
  robo_debounce #(.DEB_CYC(DEB_CYC)) u_d (
    .clk(clk), .rst(rst), .din(d), .dout(w_d));

  logic [2:0]    r_bat1, r_bat2;
  logic [EC-1:0] r_err_cnt, r_ok_cnt;
  logic          r_fault_c;
  logic          w_inv, w_low;

  assign w_inv = bat_invalid(r_bat2);
  assign w_low = (r_bat2 == BAT_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bat1    <= '0;
      r_bat2    <= '0;
      r_err_cnt <= '0;
      r_ok_cnt  <= '0;
      r_fault_c <= 1'b0;
    end else begin
      r_bat1 <= {alto, medio, baixo};
      r_bat2 <= r_bat1;
      if (w_inv) begin
        r_ok_cnt <= '0;
        if (r_err_cnt != EC'(ERR_FILT_CYC))
          r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt >= EC'(ERR_FILT_CYC - 1))
          r_fault_c <= 1'b1;
      end else begin
        r_err_cnt <= '0;
        if (r_ok_cnt != EC'(ERR_FILT_CYC))
          r_ok_cnt <= r_ok_cnt + 1'b1;
        if (r_ok_cnt >= EC'(ERR_FILT_CYC - 1))
          r_fault_c <= 1'b0;
      end
    end
  end

  // conflicting pairs cancel; remaining one-hot gives F > A > E > D
  logic       w_cf, w_ca, w_ce, w_cd;
  logic       w_cmd_v;
  logic [1:0] w_cmd;

  assign w_cf = w_f & !w_a;
  assign w_ca = w_a & !w_f;
  assign w_ce = w_e & !w_d & !(w_cf | w_ca);
  assign w_cd = w_d & !w_e & !(w_cf | w_ca);

  always_comb begin
    w_cmd_v = 1'b1;
    w_cmd   = DIR_F;
    unique case (1'b1)
      w_cf:    w_cmd = DIR_F;
      w_ca:    w_cmd = DIR_A;
      w_ce:    w_cmd = DIR_E;
      w_cd:    w_cmd = DIR_D;
      default: w_cmd_v = 1'b0;
    endcase
  end

  state_t        r_state, w_nxt;
  logic [1:0]    r_dir, w_nxt_dir;
  logic [MC-1:0] r_move_cnt, w_nxt_cnt;
  logic          r_move, r_fault, r_low_batt, r_rgb_ok;

  always_comb begin
    w_nxt     = r_state;
    w_nxt_dir = r_dir;
    w_nxt_cnt = r_move_cnt;
    if (!w_ld) begin
      w_nxt = ST_OFF;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          if (r_fault_c)  w_nxt = ST_FAULT;
          else if (w_low) w_nxt = ST_LOW;
          else            w_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (r_fault_c)  w_nxt = ST_FAULT;
          else if (w_low) w_nxt = ST_LOW;
          else if (w_cmd_v) begin
            w_nxt     = ST_MOVE;
            w_nxt_dir = w_cmd;
            w_nxt_cnt = '0;
          end
        end
        ST_MOVE: begin
          if (r_fault_c) begin
            w_nxt = ST_FAULT;
          end else if (r_move_cnt < MC'(MIN_MOVE_CYC - 1)) begin
            w_nxt_cnt = r_move_cnt + 1'b1;
          end else if (w_low) begin
            w_nxt = ST_LOW;
          end else if (w_cmd_v && w_cmd != r_dir) begin
            w_nxt_dir = w_cmd;
            w_nxt_cnt = '0;
          end else if (!w_cmd_v) begin
            w_nxt = ST_IDLE;
          end
        end
        ST_LOW: begin
          if (r_fault_c)            w_nxt = ST_FAULT;
          else if (!w_low && !w_inv) w_nxt = ST_IDLE;
        end
        ST_FAULT: begin
          if (!r_fault_c) w_nxt = ST_IDLE;
        end
        default: w_nxt = ST_OFF;
      endcase
    end
  end

  // outputs decode the next state so they change with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_dir      <= DIR_F;
      r_move_cnt <= '0;
      r_move     <= 1'b0;
      r_fault    <= 1'b0;
      r_low_batt <= 1'b0;
      r_rgb_ok   <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_dir      <= w_nxt_dir;
      r_move_cnt <= w_nxt_cnt;
      r_move     <= (w_nxt == ST_MOVE);
      r_fault    <= (w_nxt == ST_FAULT);
      r_low_batt <= w_low && (w_nxt != ST_OFF);
      r_rgb_ok   <= (w_nxt == ST_IDLE) || (w_nxt == ST_MOVE)
                 || (w_nxt == ST_LOW);
    end
  end

  assign move     = r_move;
  assign dir      = r_dir;
  assign state    = r_state;
  assign fault    = r_fault;
  assign low_batt = r_low_batt;
  assign rgb_ok   = r_rgb_ok;

endmodule
